sma_channel_ctrl: RTL and testbench

SMA_CHANNEL_CTRL -- requirements
Module: sma_channel_ctrl

---
 rtl/sma_ctrl_pkg.sv | 36 +++
 rtl/sma_ch_fsm.sv | 109 ++++++++++
 rtl/sma_channel_ctrl.sv | 128 ++++++++++++
 tb/tb_sma_channel_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sma_ctrl_pkg.sv
// Shared definitions for the stream-memory-accessor channel controller:
// channel state encoding, register word map and status bit positions.
package sma_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    localparam int unsigned WORD_W           = 64;
    localparam int unsigned NUM_WORDS        = 32;

    // Write/read word offsets
    localparam int unsigned CTRL             = 0;
    localparam int unsigned CFG              = 1;
    localparam int unsigned ADDR_BASE        = 2;
    localparam int unsigned CNT_BASE         = 2;
    localparam int unsigned ADDR_REGS_PER_CH = 4;

    // Bit positions inside the control and status words
    localparam int unsigned CLR_DONE_BIT     = 0;
    localparam int unsigned RUN_LSB          = 8;
    localparam int unsigned DONE_LSB         = 0;
    localparam int unsigned BUSY_LSB         = 8;
    localparam int unsigned REQ_LSB          = 16;
    localparam int unsigned ERR_LSB          = 0;
    localparam int unsigned OVR_LSB          = 8;

    // Word index of address register idx (0=ral,1=rah,2=wal,3=wah) of channel ch
    function automatic int unsigned addr_word(input int unsigned ch, input int unsigned idx);
        return ADDR_BASE + ADDR_REGS_PER_CH * ch + idx;
    endfunction

endpackage

// File: rtl/sma_ch_fsm.sv
// One accessor channel: IDLE/ARMED/BUSY/DONE sequencing, ARMED timeout,
// saturating activity counter and sticky error/overrun flags.
module sma_ch_fsm
    import sma_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run_req,
    input  logic                 i_clr_done,
    input  logic                 i_req,
    output logic                 o_run_c,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_ovr,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    ch_state_e            r_state;
    logic [TMR_W-1:0]     r_tmr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_err;
    logic                 r_ovr;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_accept;

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    assign w_accept  = i_run_req & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Start pulse is visible in the same cycle the request is accepted
    assign o_run_c = rst & w_accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_run_req) begin
                        r_state <= ST_ARMED;
                        r_tmr   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_ovr   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else if ((r_state == ST_DONE) && i_clr_done) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    r_cnt <= w_cnt_inc;
                    if (i_run_req) begin
                        r_ovr <= 1'b1;
                    end
                    if (i_req) begin
                        r_state <= ST_BUSY;
                    end else if (r_tmr == TMR_LAST) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (i_run_req) begin
                        r_ovr <= 1'b1;
                    end
                    if (!i_req) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_ovr  = r_ovr;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/sma_channel_ctrl.sv
// Local-bus register block for NUM_CH stream-memory-accessor channels:
// address/config registers, edge-detected run requests, status image and irq.
module sma_channel_ctrl
    import sma_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [63:0]                     reg_in,
    input  logic [255:0]                    reg_wr,
    output logic [2047:0]                   reg_out,
    input  logic [NUM_CH-1:0]               req,
    output logic [NUM_CH-1:0]               run,
    output logic [ADDRESS_WIDTH*NUM_CH-1:0] ral,
    output logic [ADDRESS_WIDTH*NUM_CH-1:0] rah,
    output logic [ADDRESS_WIDTH*NUM_CH-1:0] wal,
    output logic [ADDRESS_WIDTH*NUM_CH-1:0] wah,
    output logic                            irq
);

    logic [NUM_WORDS-1:0] w_wr;
    logic                 w_clr_done;
    logic [NUM_CH-1:0]    w_run_lvl;
    logic [NUM_CH-1:0]    w_run_req;
    logic [NUM_CH-1:0]    w_busy;
    logic [NUM_CH-1:0]    w_done;
    logic [NUM_CH-1:0]    w_err;
    logic [NUM_CH-1:0]    w_ovr;
    logic [CNT_WIDTH-1:0] w_cnt [NUM_CH];
    logic                 w_unused;

    logic [NUM_CH-1:0]    r_run_prev;
    logic [NUM_CH-1:0]    r_irq_en;
    logic                 r_irq;

    // Only the lowest byte-enable of each 64-bit word acts as its strobe
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_strobe
        assign w_wr[k] = reg_wr[8*k];
    end

    assign w_unused   = ^{reg_in, reg_wr};
    assign w_clr_done = w_wr[CTRL] & reg_in[CLR_DONE_BIT];
    assign w_run_lvl  = {NUM_CH{w_wr[CTRL]}} & reg_in[RUN_LSB +: NUM_CH];
    assign w_run_req  = w_run_lvl & ~r_run_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run_prev <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_run_prev <= w_run_lvl;
            r_irq      <= |(w_done & r_irq_en);
            if (w_wr[CFG]) begin
                r_irq_en <= reg_in[NUM_CH-1:0];
            end
        end
    end

    assign irq = r_irq;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned RAL_WORD = addr_word(c, 0);
        localparam int unsigned RAH_WORD = addr_word(c, 1);
        localparam int unsigned WAL_WORD = addr_word(c, 2);
        localparam int unsigned WAH_WORD = addr_word(c, 3);

        logic [ADDRESS_WIDTH-1:0] r_ral;
        logic [ADDRESS_WIDTH-1:0] r_rah;
        logic [ADDRESS_WIDTH-1:0] r_wal;
        logic [ADDRESS_WIDTH-1:0] r_wah;

        // Address registers stay writable in every channel state
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_ral <= '0;
                r_rah <= '0;
                r_wal <= '0;
                r_wah <= '0;
            end else begin
                if (w_wr[RAL_WORD]) r_ral <= reg_in[ADDRESS_WIDTH-1:0];
                if (w_wr[RAH_WORD]) r_rah <= reg_in[ADDRESS_WIDTH-1:0];
                if (w_wr[WAL_WORD]) r_wal <= reg_in[ADDRESS_WIDTH-1:0];
                if (w_wr[WAH_WORD]) r_wah <= reg_in[ADDRESS_WIDTH-1:0];
            end
        end

        assign ral[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_ral;
        assign rah[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_rah;
        assign wal[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_wal;
        assign wah[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_wah;

        sma_ch_fsm #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .i_run_req  (w_run_req[c]),
            .i_clr_done (w_clr_done),
            .i_req      (req[c]),
            .o_run_c    (run[c]),
            .o_busy     (w_busy[c]),
            .o_done     (w_done[c]),
            .o_err      (w_err[c]),
            .o_ovr      (w_ovr[c]),
            .o_cnt      (w_cnt[c])
        );
    end

    // Read-back image; every bit not listed here reads as zero
    always_comb begin
        reg_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            reg_out[CTRL*WORD_W + DONE_LSB + c] = w_done[c];
            reg_out[CTRL*WORD_W + BUSY_LSB + c] = w_busy[c];
            reg_out[CTRL*WORD_W + REQ_LSB  + c] = req[c];
            reg_out[CFG*WORD_W  + ERR_LSB  + c] = w_err[c];
            reg_out[CFG*WORD_W  + OVR_LSB  + c] = w_ovr[c];
            reg_out[(CNT_BASE + c)*WORD_W +: WORD_W] = WORD_W'(w_cnt[c]);
        end
    end

endmodule

// File: tb/tb_sma_channel_ctrl.sv
// Directed plus randomized bench for sma_channel_ctrl against a behavioural
// channel model kept in plain integers.
module tb_sma_channel_ctrl;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int TO  = 16;
    localparam int CW  = 32;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [63:0]         reg_in;
    logic [255:0]        reg_wr;
    logic [2047:0]       reg_out;
    logic [NCH-1:0]      req;
    logic [NCH-1:0]      run;
    logic [AW*NCH-1:0]   ral, rah, wal, wah;
    logic                irq;

    always #5 clk = ~clk;

    sma_channel_ctrl #(
        .NUM_CH         (NCH),
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .reg_in  (reg_in),
        .reg_wr  (reg_wr),
        .reg_out (reg_out),
        .req     (req),
        .run     (run),
        .ral     (ral),
        .rah     (rah),
        .wal     (wal),
        .wah     (wah),
        .irq     (irq)
    );

    typedef enum {M_IDLE, M_ARMED, M_BUSY, M_DONE} mstate_e;

    mstate_e         m_st   [NCH];
    longint          m_cnt  [NCH];
    int              m_wait [NCH];
    bit              m_err  [NCH];
    bit              m_ovr  [NCH];
    bit              m_prev [NCH];
    logic [AW-1:0]   m_addr [NCH][4];
    bit [NCH-1:0]    m_irq_en;
    bit              m_irq;

    int              checks = 0;
    int              errors = 0;
    logic [NCH-1:0]  run_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w == 0) begin
                v[c]      = (m_st[c] == M_DONE);
                v[8 + c]  = (m_st[c] == M_ARMED) || (m_st[c] == M_BUSY);
                v[16 + c] = req[c];
            end else if (w == 1) begin
                v[c]     = m_err[c];
                v[8 + c] = m_ovr[c];
            end else if (w == 2 + c) begin
                v = 64'(m_cnt[c]);
            end
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_run();
        logic [NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            r[c] = rst && reg_wr[0] && reg_in[8 + c] && !m_prev[c] &&
                   ((m_st[c] == M_IDLE) || (m_st[c] == M_DONE));
        end
        return r;
    endfunction

    function automatic logic [AW*NCH-1:0] exp_addr(input int k);
        logic [AW*NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*AW +: AW] = m_addr[c][k];
        return v;
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_edge();
        bit clr, lvl, rr;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_st[c] = M_IDLE; m_cnt[c] = 0; m_wait[c] = 0;
                m_err[c] = 0; m_ovr[c] = 0; m_prev[c] = 0;
                for (int k = 0; k < 4; k++) m_addr[c][k] = '0;
            end
            m_irq_en = '0;
            m_irq    = 0;
            return;
        end
        m_irq = 0;
        for (int c = 0; c < NCH; c++) if (m_st[c] == M_DONE && m_irq_en[c]) m_irq = 1;
        clr = reg_wr[0] && reg_in[0];
        for (int c = 0; c < NCH; c++) begin
            lvl = reg_wr[0] && reg_in[8 + c];
            rr  = lvl && !m_prev[c];
            m_prev[c] = lvl;
            case (m_st[c])
                M_IDLE, M_DONE: begin
                    if (rr) begin
                        m_st[c] = M_ARMED; m_cnt[c] = 0; m_wait[c] = 0;
                        m_err[c] = 0; m_ovr[c] = 0;
                    end else if (m_st[c] == M_DONE && clr) begin
                        m_st[c] = M_IDLE;
                    end
                end
                M_ARMED: begin
                    if (m_cnt[c] < CMAX) m_cnt[c]++;
                    if (rr) m_ovr[c] = 1;
                    if (req[c]) m_st[c] = M_BUSY;
                    else begin
                        m_wait[c]++;
                        if (m_wait[c] == TO) begin
                            m_st[c] = M_DONE; m_err[c] = 1;
                        end
                    end
                end
                M_BUSY: begin
                    if (m_cnt[c] < CMAX) m_cnt[c]++;
                    if (rr) m_ovr[c] = 1;
                    if (!req[c]) m_st[c] = M_DONE;
                end
                default: ;
            endcase
            for (int k = 0; k < 4; k++)
                if (reg_wr[8 * (2 + 4 * c + k)]) m_addr[c][k] = reg_in[AW-1:0];
        end
        if (reg_wr[8]) m_irq_en = reg_in[NCH-1:0];
    endtask

    task automatic tick(input logic [63:0] din, input logic [255:0] wr,
                        input logic [NCH-1:0] rq, input logic rv);
        @(negedge clk);
        reg_in = din; reg_wr = wr; req = rq; rst = rv;
        #1;
        run_seen = run;
        chk("run", 64'(run), 64'(exp_run()));
        @(posedge clk);
        model_edge();
        #1;
        for (int w = 0; w < 32; w++)
            chk($sformatf("reg_out_w%0d", w), reg_out[w*64 +: 64], exp_word(w));
        chk("irq", 64'(irq), 64'(m_irq));
        chk("ral", 64'(ral), 64'(exp_addr(0)));
        chk("rah", 64'(rah), 64'(exp_addr(1)));
        chk("wal", 64'(wal), 64'(exp_addr(2)));
        chk("wah", 64'(wah), 64'(exp_addr(3)));
    endtask

    task automatic wr_word(input int w, input logic [63:0] d, input logic [NCH-1:0] rq);
        logic [255:0] m;
        m = '0;
        m[8*w] = 1'b1;
        tick(d, m, rq, 1'b1);
    endtask

    initial begin
        logic [63:0]    d;
        logic [255:0]   w;
        logic [NCH-1:0] rq_r;
        logic           rv;
        longint         cnt;

        rst = 1'b0; reg_in = '0; reg_wr = '0; req = '0;
        repeat (3) tick('0, '0, '0, 1'b0);
        chk("rst_word0", reg_out[63:0], 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        tick('0, '0, '0, 1'b1);

        // Address write then run on channel 0
        wr_word(1, 64'h1, 2'b00);
        wr_word(2, 64'h100, 2'b00);
        chk("ral0_written", 64'(ral[31:0]), 64'h100);
        wr_word(0, 64'h100, 2'b00);
        chk("run_pulse", 64'(run_seen), 64'h1);
        chk("busy_bit", 64'(reg_out[8]), 64'h1);

        // Strobe held a second cycle: no second pulse; req activity starts
        wr_word(0, 64'h100, 2'b01);
        chk("run_held_no_pulse", 64'(run_seen), 64'h0);
        repeat (18) tick('0, '0, 2'b01, 1'b1);
        wr_word(0, 64'h100, 2'b01);
        chk("run_in_busy_ignored", 64'(run_seen), 64'h0);
        chk("ovr_set", 64'(reg_out[64 + 8]), 64'h1);
        repeat (30) tick('0, '0, 2'b01, 1'b1);
        tick('0, '0, 2'b00, 1'b1);
        cnt = longint'(reg_out[128 +: 64]);
        chk("done_bit", 64'(reg_out[0]), 64'h1);
        chk("cnt_about_51", 64'((cnt >= 50) && (cnt <= 52)), 64'h1);
        chk("irq_not_yet", 64'(irq), 64'h0);
        tick('0, '0, 2'b00, 1'b1);
        chk("irq_rise", 64'(irq), 64'h1);

        // Run together with clear-done in DONE: run wins, ovr cleared
        wr_word(0, 64'h101, 2'b00);
        chk("run_over_clear", 64'(run_seen), 64'h1);
        chk("armed_after_both", 64'(reg_out[8]), 64'h1);
        chk("ovr_cleared", 64'(reg_out[64 + 8]), 64'h0);

        // ARMED timeout
        repeat (15) tick('0, '0, 2'b00, 1'b1);
        chk("no_early_timeout", 64'(reg_out[0]), 64'h0);
        tick('0, '0, 2'b00, 1'b1);
        chk("timeout_done", 64'(reg_out[0]), 64'h1);
        chk("timeout_err", 64'(reg_out[64]), 64'h1);
        chk("timeout_cnt", reg_out[128 +: 64], 64'd16);

        // Clear-done returns to IDLE
        wr_word(0, 64'h1, 2'b00);
        chk("clear_to_idle", reg_out[63:0], 64'h0);

        // Channel 0 to DONE with irq, channel 1 busy, then reset
        wr_word(0, 64'h100, 2'b00);
        repeat (3) tick('0, '0, 2'b01, 1'b1);
        tick('0, '0, 2'b00, 1'b1);
        tick('0, '0, 2'b00, 1'b1);
        chk("irq_before_rst", 64'(irq), 64'h1);
        wr_word(0, 64'h200, 2'b10);
        chk("run_ch1", 64'(run_seen), 64'h2);
        repeat (5) tick('0, '0, 2'b10, 1'b1);
        chk("ch1_busy", 64'(reg_out[9]), 64'h1);
        tick('0, '0, 2'b00, 1'b0);
        chk("rst_status0", reg_out[63:0], 64'h0);
        chk("rst_status1", reg_out[127:64], 64'h0);
        chk("rst_cnt1", reg_out[255:192], 64'h0);
        chk("rst_irq_low", 64'(irq), 64'h0);
        tick('0, '0, 2'b00, 1'b1);

        // Randomized traffic
        rq_r = '0;
        for (int i = 0; i < 800; i++) begin
            d = {$urandom, $urandom};
            w = '0;
            for (int b = 0; b < 256; b++) begin
                if (b % 8 != 0) w[b] = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 9) == 0) w[b] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) w[0] = 1'b1;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 7) == 0) rq_r[c] = ~rq_r[c];
            rv = ($urandom_range(0, 249) != 0);
            tick(d, w, rq_r, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
